// File: rtl/truth_table_lut.sv
// Reloadable N_IN-input truth table with a registered input path and a settle
// filter that only lets the output change once the looked-up value is stable.
module truth_table_lut #(
   parameter int unsigned          N_IN     = 3,
   parameter logic [2**N_IN-1:0]   RESET_TT = 8'h42,
   parameter int unsigned          SETTLE   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_IN-1:0] in,
   input  logic            cfg_start,
   input  logic            cfg_valid,
   input  logic            cfg_bit,
   output logic            cfg_ready,
   output logic            busy,
   output logic            out,
   output logic            out_valid
);

   localparam int unsigned TW = 2**N_IN;
   localparam int unsigned CW = $clog2(TW) + 1;

   typedef enum logic {StRun, StLoad} state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   active_q, active_d;
   logic [TW-1:0]   shadow_q, shadow_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic            commit;

   logic [N_IN-1:0] in_q;
   logic            raw;
   logic            cand_q;
   logic [7:0]      cnt_q;
   logic            out_q;
   logic            out_valid_q;

   // Config FSM: the final accepted bit commits on the same edge, so a
   // coincident cfg_start is simply never looked at.
   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      bit_cnt_d = bit_cnt_q;
      commit    = 1'b0;
      unique case (state_q)
         StRun: begin
            if (cfg_start) begin
               state_d   = StLoad;
               bit_cnt_d = '0;
            end
         end
         StLoad: begin
            if (cfg_valid) begin
               shadow_d[bit_cnt_q[N_IN-1:0]] = cfg_bit;
               bit_cnt_d = bit_cnt_q + CW'(1);
               if (bit_cnt_q == CW'(TW - 1)) begin
                  active_d = shadow_d;
                  state_d  = StRun;
                  commit   = 1'b1;
               end
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StRun;
         active_q  <= RESET_TT;
         shadow_q  <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign raw = active_q[in_q];

   // Settle filter; a commit restarts qualification but out keeps its old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q        <= '0;
         cand_q      <= 1'b0;
         cnt_q       <= '0;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         in_q <= in;
         if (commit) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
         end else if (raw != cand_q) begin
            cand_q <= raw;
            cnt_q  <= '0;
         end else if (cnt_q < 8'(SETTLE - 1)) begin
            cnt_q <= cnt_q + 8'd1;
         end else begin
            out_q       <= cand_q;
            out_valid_q <= 1'b1;
         end
      end
   end

   assign busy      = (state_q == StLoad);
   assign cfg_ready = (state_q == StLoad);
   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_truth_table_lut.sv
// Directed bench: settle latency, glitch rejection, serial reload, reset
// mid-load, cfg_start collisions, and a 4-input instance.
module tb_truth_table_lut;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] in_a = 3'b000;
   logic [3:0] in_b = 4'h0;
   logic       cfg_start = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_bit = 1'b0;
   logic       idle0 = 1'b0;
   logic       cfg_ready, busy, out, out_valid;
   logic       cfg_ready4, busy4, out4, out_valid4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   truth_table_lut dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in_a),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_ready (cfg_ready),
      .busy      (busy),
      .out       (out),
      .out_valid (out_valid)
   );

   truth_table_lut #(
      .N_IN     (4),
      .RESET_TT (16'h8000),
      .SETTLE   (4)
   ) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in        (in_b),
      .cfg_start (idle0),
      .cfg_valid (idle0),
      .cfg_bit   (idle0),
      .cfg_ready (cfg_ready4),
      .busy      (busy4),
      .out       (out4),
      .out_valid (out_valid4)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One idle cycle then one accepted bit; cfg_start optionally on either cycle.
   task automatic send_bit(input logic b, input logic start_gap, input logic start_valid);
      cfg_valid = 1'b0;
      cfg_start = start_gap;
      tick(1);
      check("busy_gap", busy, 1'b1);
      check("ready_gap", cfg_ready, 1'b1);
      cfg_valid = 1'b1;
      cfg_bit   = b;
      cfg_start = start_valid;
      tick(1);
      cfg_valid = 1'b0;
      cfg_start = 1'b0;
   endtask

   initial begin
      logic [7:0] tt;
      rst = 1'b0;
      #1 rst = 1'b1;
      tick(2);
      check("rst_out", out, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", cfg_ready, 1'b0);

      // Settle latency from reset with in=001 (table bit1=1)
      rst  = 1'b0;
      in_a = 3'b001;
      tick(5);
      check("lat_e5_out", out, 1'b0);
      check("lat_e5_valid", out_valid, 1'b0);
      tick(1);
      check("lat_e6_out", out, 1'b1);
      check("lat_e6_valid", out_valid, 1'b1);

      in_a = 3'b110;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("hold_110", out, 1'b1);
      end
      in_a = 3'b111;
      tick(5);
      check("e5_111", out, 1'b1);
      tick(1);
      check("e6_111", out, 1'b0);

      // Short glitch must not reach out
      in_a = 3'b001;
      tick(8);
      check("pre_glitch", out, 1'b1);
      in_a = 3'b000;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("glitch", out, 1'b1);
      end
      in_a = 3'b001;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("post_glitch", out, 1'b1);
      end

      // Reload 8'h81 with gaps; old table stays live during load
      in_a = 3'b111;
      tick(8);
      check("pre_load", out, 1'b0);
      cfg_start = 1'b1;
      tick(1);
      cfg_start = 1'b0;
      check("load_busy", busy, 1'b1);
      tt = 8'h81;
      for (int i = 0; i < 8; i++) begin
         send_bit(tt[i], 1'b0, 1'b0);
         if (i < 7) begin
            check("load_busy_acc", busy, 1'b1);
            check("load_old_tt", out, 1'b0);
         end
      end
      check("commit_busy", busy, 1'b0);
      check("commit_ready", cfg_ready, 1'b0);
      check("commit_valid_clr", out_valid, 1'b0);
      check("commit_out_hold", out, 1'b0);
      tick(8);
      check("new_111", out, 1'b1);
      check("new_valid", out_valid, 1'b1);
      in_a = 3'b001;
      tick(8);
      check("new_001", out, 1'b0);

      // Reset halfway through a load restores RESET_TT
      cfg_start = 1'b1;
      tick(1);
      cfg_start = 1'b0;
      tt = 8'hFF;
      for (int i = 0; i < 4; i++) send_bit(tt[i], 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_ready", cfg_ready, 1'b0);
      check("midrst_out", out, 1'b0);
      tick(1);
      rst  = 1'b0;
      in_a = 3'b110;
      tick(8);
      check("midrst_110", out, 1'b1);
      in_a = 3'b111;
      tick(8);
      check("midrst_111", out, 1'b0);

      // cfg_start mid-load and on the final bit are both ignored
      in_a = 3'b011;
      tick(8);
      check("pre_coll_011", out, 1'b0);
      cfg_start = 1'b1;
      tick(1);
      cfg_start = 1'b0;
      tt = 8'h18;
      for (int i = 0; i < 8; i++) send_bit(tt[i], (i == 3), (i == 7));
      check("coll_busy", busy, 1'b0);
      check("coll_ready", cfg_ready, 1'b0);
      tick(1);
      check("coll_busy_next", busy, 1'b0);
      tick(8);
      check("coll_011", out, 1'b1);
      in_a = 3'b111;
      tick(8);
      check("coll_111", out, 1'b0);

      // 4-input instance: only 4'hF maps to 1
      for (int v = 0; v < 16; v++) begin
         in_b = 4'(v);
         tick(8);
         check("n4_out", out4, (v == 15));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_lut.md
TRUTH_TABLE_LUT -- requirements
Module: truth_table_lut

Interface
REQ-001 Parameter N_IN, default 3: number of logic inputs; legal range 1..6.
REQ-002 Parameter RESET_TT, default 8'h42: power-on truth table, width 2**N_IN; bit k is the output for input vector value k.
REQ-003 Parameter SETTLE, default 4: consecutive stable cycles required before out changes; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 in  input  N_IN  logic input vector; in[N_IN-1] is the MSB of the table index.
REQ-007 cfg_start  input  1  one-cycle request to begin reloading the truth table.
REQ-008 cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-009 cfg_bit  input  1  serial truth-table bit, table bit 0 first.
REQ-010 cfg_ready  output  1  block accepts a cfg_bit this cycle.
REQ-011 busy  output  1  reload in progress.
REQ-012 out  output  1  filtered logic output.
REQ-013 out_valid  output  1  out reflects the active table for the current settled input.

Function
REQ-014 The block SHALL implement a two-state FSM: RUN and LOAD.
REQ-015 In RUN, cfg_start=1 SHALL move the FSM to LOAD on the next edge and clear the bit counter to 0.
REQ-016 In LOAD, cfg_start SHALL be ignored.
REQ-017 busy and cfg_ready SHALL both be 1 exactly while in LOAD.
REQ-018 In LOAD, each cycle with cfg_valid=1 SHALL write cfg_bit into shadow bit [counter] and increment the counter.
REQ-019 Cycles in LOAD with cfg_valid=0 SHALL change nothing.
REQ-020 On acceptance of bit 2**N_IN-1, the block SHALL on the same edge copy the full shadow (including that bit) into the active table and return to RUN.
REQ-021 The active table SHALL remain unchanged throughout LOAD.
REQ-022 Evaluation SHALL continue normally during LOAD, using the old table.
REQ-023 Input path: in_q <= in every edge; raw = active_table[in_q].
REQ-024 Settle filter: if raw != cand, then cand <= raw and cnt <= 0.
REQ-025 Settle filter: else if cnt < SETTLE-1, then cnt <= cnt+1.
REQ-026 Settle filter: else out <= cand and out_valid <= 1.
REQ-027 Latency: with in stable, out SHALL take the new value on the (SETTLE+2)-th rising edge after in changes.
REQ-028 Input glitches shorter than SETTLE cycles SHALL NOT change out.
REQ-029 On the table-commit edge, the block SHALL clear cnt and out_valid.
REQ-030 On the table-commit edge, out SHALL hold its value until the filter completes against the new table.
REQ-031 When cfg_start and the final config bit coincide, the commit SHALL take priority and cfg_start SHALL be dropped.
REQ-032 The bit counter SHALL be clog2(2**N_IN)+1 bits wide and SHALL never wrap.
REQ-033 cnt SHALL be 8 bits wide.

Reset
REQ-034 While rst=1: FSM=RUN, active table=RESET_TT, shadow=0, bit counter=0.
REQ-035 While rst=1: in_q=0, cand=0, cnt=0.
REQ-036 While rst=1: out=0, out_valid=0, cfg_ready=0, busy=0.
REQ-037 rst asserted mid-LOAD SHALL discard the partial load and restore RESET_TT.

Verification
REQ-038 Default parameters, after reset, drive in=3'b001 and hold -> out=1 and out_valid=1 from edge 6 onward; drive in=3'b110 -> out stays 1; drive in=3'b111 -> out=0 on edge 6.
REQ-039 in=3'b001 held steady, then in=3'b000 pulsed for 3 cycles (SETTLE=4) -> out stays 1 throughout.
REQ-040 Pulse cfg_start, then shift 8 bits of 8'h81 with cfg_valid gaps -> busy high for the whole load; after the 8th accepted bit, in=3'b111 gives out=1 and in=3'b001 gives out=0.
REQ-041 rst pulsed after 4 of 8 config bits -> busy=0, table=8'h42, and in=3'b110 gives out=1.
REQ-042 cfg_start issued while in LOAD and on the final-bit cycle -> no restart; FSM returns to RUN and cfg_ready=0.
REQ-043 N_IN=4, RESET_TT=16'h8000 -> out=1 only for in=4'hF; every other value gives out=0.
